jedro_1_csr_ext: RTL
====================

// Module: jedro_1_csr_ext
// PURPOSE
//  Parametrised successor of the machine-mode CSR file. Adds 64-bit mcycle/minstret, NUM_HPM event
//  counters, mcountinhibit, NUM_FAST_IRQ platform interrupts, vectored mtvec and interrupt trap entry.
//  Sits beside the decoder; drives trap redirect to the IFU; exceptions come pre-prioritised.
// PARAMETERS
//  DATA_WIDTH    32  datapath/CSR width (only 32 supported)
//  NUM_HPM       4   mhpmcounter3..3+NUM_HPM-1 implemented, range 0..29
//  HPM_WIDTH     40  implemented bits per HPM counter, range 1..64; upper bits read 0
//  NUM_FAST_IRQ  4   platform irqs at mip/mie bits 16+i, mcause code 16+i, range 0..16
// PORTS
//  clk_i            in   1           clock, rising edge
//  rst_i            in   1           synchronous active-high reset
//  addr_i           in   12          CSR address
//  wdata_i          in   DATA_WIDTH  rs1 write data
//  uimm_i           in   5           zimm write data
//  uimm_sel_i       in   1           1: use zero-extended uimm_i as write data
//  we_i             in   1           CSR write request
//  wmode_i          in   2           CSR_WMODE_NORMAL / SET_BITS / CLEAR_BITS
//  rdata_o          out  DATA_WIDTH  registered read data of addr_i
//  csr_illegal_o    out  1           comb: write to read-only or unimplemented CSR
//  exc_valid_i      in   1           exception from decoder/LSU/IFU this cycle
//  exc_cause_i      in   5           exception code (mcause[4:0], bit 31 = 0)
//  exc_pc_i         in   DATA_WIDTH  faulting pc -> mepc
//  exc_tval_i       in   DATA_WIDTH  -> mtval
//  mret_i           in   1           mret executed
//  irq_window_i     in   1           current instr at an interruptible boundary
//  curr_pc_i        in   DATA_WIDTH  pc of next instr to execute (irq mepc)
//  instr_ret_i      in   1           one instr retired
//  hpm_event_i      in   NUM_HPM     per-counter increment strobe
//  irq_sw_i/irq_timer_i/irq_ext_i in 1  level irq lines
//  irq_fast_i       in   NUM_FAST_IRQ level irq lines
//  trap_o           out  1           1-cycle pulse: redirect fetch
//  trap_addr_o      out  DATA_WIDTH  redirect target, valid with trap_o
// BEHAVIOUR
//  Reset: rdata_o=0, trap_o=0, trap_addr_o=0, mstatus.MIE/MPIE=0, mie=0, mcountinhibit=0, counters=0,
//   mtvec={TRAP_VEC_BASE_ADDR,2'b00} (direct), mepc/mcause/mtval/mscratch=0. Reset mid-trap drops pending pulse.
//  Read: rdata_o <= value(addr_i) next edge, every cycle. Write data = wmode applied to pre-write value.
//  Write effect visible at next edge; suppressed when exc_valid_i, csr_illegal_o or trap taken this cycle.
//  csr_illegal_o = (we_i|uimm_sel_i) & (addr read-only (mvendorid..mhartid, misa, mip) | unimplemented).
//   Unimplemented HPM counters 3+NUM_HPM..31, mhpmevent3..31: legal, read 0, writes ignored.
//  mtvec: MODE bit0 writable (0 direct, 1 vectored), bit1 reads 0; base bits[31:2].
//  mip: bit3 MSIP, 7 MTIP, 11 MEIP, 16+i fast; registered from inputs, 1-cycle latency; read-only.
//  irq_pend = mip & mie; irq_take = MIE & |irq_pend & irq_window_i & !exc_valid_i & !mret_i.
//  Priority: exc > mret > irq. Irq order: ext(11) > sw(3) > timer(7) > fast[0] > ... > fast[N-1].
//  Trap entry (exc or irq): mepc<=exc_pc_i|curr_pc_i, mcause<={irq,26'b0,code}, mtval<=exc_tval_i|0,
//   MPIE<=MIE, MIE<=0. trap_addr_o = base<<2, or base<<2 + 4*code if irq and MODE=1.
//  mret: MIE<=MPIE, MPIE<=1, trap_addr_o<=mepc. trap_o<=exc|mret|irq_take, registered, 1 cycle.
//  Counters: mcycle += !inhibit[0]; minstret += instr_ret_i & !inhibit[2];
//   hpm[i] += hpm_event_i[i] & !inhibit[3+i]. 64-bit wrap 2^64-1 -> 0; HPM wraps at 2^HPM_WIDTH.
//   lo/hi CSRs written separately (mcycle/h 0xB00/0xB80, minstret/h 0xB02/0xB82, hpm 0xB03+/0xB83+);
//   write to a half replaces that half and suppresses that cycle's increment of the whole counter.
//   mcountinhibit: bits 0, 2, 3..3+NUM_HPM-1 writable, others read 0.
// STRUCTURE
//  jedro_1_defines: CSR_ADDR_MCYCLE(H), MINSTRET(H), MHPMCOUNTER3(H), MHPMEVENT3, MCOUNTINHIBIT,
//   CSR_MTVEC_MODE_DIRECT/VECTORED, CSR_MCAUSE_IRQ_SW/TIMER/EXT, CSR_MIP_BIT_FAST_BASE=16.
//  Sub-module jedro_1_csr_counter #(WIDTH): inc_i, inhibit_i, we_lo_i, we_hi_i, wdata_i, count_o;
//   instantiated for mcycle, minstret and via generate for each HPM counter.
// TESTING
//  mcycle lo=32'hFFFF_FFFF, hi=32'hFFFF_FFFF, run 2 cycles -> mcycle reads 0 then 1; mcycleh 0.
//  Write minstret=5 while instr_ret_i=1 -> reads 5 next; inhibit[2]=1 + 3 retires -> stays 5.
//  mtvec=0x0000_0101 (vectored), MIE=1, mie.MTIE=1, irq_timer_i=1, window=1 -> trap_o, addr 0x11C,
//   mcause 0x8000_0007, MIE=0, MPIE=1; then mret -> trap_addr_o=mepc, MIE=1.
//  irq_ext_i & irq_sw_i & exc_valid_i(cause 2) same cycle -> exception taken, mcause=2, addr=base.
//  Write mvendorid -> csr_illegal_o=1, no state change; write mhpmcounter31 (NUM_HPM=4) -> legal, reads 0.
//  NUM_HPM=2, HPM_WIDTH=8: hpm3=0xFF + event -> 0; mhpmcounter3h reads 0; reset mid-count -> all 0.

Source files
------------

// File: rtl/jedro_1_csr_ext_pkg.sv
// ---------------------------------------------------------------------------
// jedro_1_csr_ext_pkg
// Shared definitions for the extended machine-mode CSR file: CSR addresses,
// write modes, mtvec modes, interrupt cause codes / mip bit positions and the
// read-modify-write helper used for CSRRW/CSRRS/CSRRC.
// No ports (package).
// ---------------------------------------------------------------------------
package jedro_1_csr_ext_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    CSR_WMODE_NORMAL     = 2'b00,
    CSR_WMODE_SET_BITS   = 2'b01,
    CSR_WMODE_CLEAR_BITS = 2'b10
  } csr_wmode_e;

  // Machine information (read-only)
  localparam logic [11:0] CSR_ADDR_MVENDORID     = 12'hF11;
  localparam logic [11:0] CSR_ADDR_MARCHID       = 12'hF12;
  localparam logic [11:0] CSR_ADDR_MIMPID        = 12'hF13;
  localparam logic [11:0] CSR_ADDR_MHARTID       = 12'hF14;
  // Trap setup / handling
  localparam logic [11:0] CSR_ADDR_MSTATUS       = 12'h300;
  localparam logic [11:0] CSR_ADDR_MISA          = 12'h301;
  localparam logic [11:0] CSR_ADDR_MIE           = 12'h304;
  localparam logic [11:0] CSR_ADDR_MTVEC         = 12'h305;
  localparam logic [11:0] CSR_ADDR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_ADDR_MHPMEVENT3    = 12'h323;
  localparam logic [11:0] CSR_ADDR_MHPMEVENT31   = 12'h33F;
  localparam logic [11:0] CSR_ADDR_MSCRATCH      = 12'h340;
  localparam logic [11:0] CSR_ADDR_MEPC          = 12'h341;
  localparam logic [11:0] CSR_ADDR_MCAUSE        = 12'h342;
  localparam logic [11:0] CSR_ADDR_MTVAL         = 12'h343;
  localparam logic [11:0] CSR_ADDR_MIP           = 12'h344;
  // Counters
  localparam logic [11:0] CSR_ADDR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_ADDR_MINSTRET      = 12'hB02;
  localparam logic [11:0] CSR_ADDR_MHPMCOUNTER3  = 12'hB03;
  localparam logic [11:0] CSR_ADDR_MHPMCOUNTER31 = 12'hB1F;
  localparam logic [11:0] CSR_ADDR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] CSR_ADDR_MINSTRETH     = 12'hB82;
  localparam logic [11:0] CSR_ADDR_MHPMCOUNTER3H = 12'hB83;
  localparam logic [11:0] CSR_ADDR_MHPMCOUNTER31H = 12'hB9F;

  localparam logic CSR_MTVEC_MODE_DIRECT   = 1'b0;
  localparam logic CSR_MTVEC_MODE_VECTORED = 1'b1;

  localparam logic [4:0] CSR_MCAUSE_IRQ_SW    = 5'd3;
  localparam logic [4:0] CSR_MCAUSE_IRQ_TIMER = 5'd7;
  localparam logic [4:0] CSR_MCAUSE_IRQ_EXT   = 5'd11;

  localparam int CSR_MIP_BIT_MSIP      = 3;
  localparam int CSR_MIP_BIT_MTIP      = 7;
  localparam int CSR_MIP_BIT_MEIP      = 11;
  localparam int CSR_MIP_BIT_FAST_BASE = 16;

  // RV32I, machine mode only
  localparam logic [XLEN-1:0] MISA_VALUE = 32'h4000_0100;

  localparam logic [29:0] TRAP_VEC_BASE_ADDR_DEFAULT = 30'h0;

  // Value to store given the write mode, the CSR's pre-write value and the source.
  function automatic logic [XLEN-1:0] apply_wmode(input logic [1:0] mode,
                                                  input logic [XLEN-1:0] old_val,
                                                  input logic [XLEN-1:0] src);
    case (csr_wmode_e'(mode))
      CSR_WMODE_SET_BITS:   return old_val | src;
      CSR_WMODE_CLEAR_BITS: return old_val & ~src;
      default:              return src;
    endcase
  endfunction

endpackage

// File: rtl/jedro_1_csr_ext_if.sv
// ---------------------------------------------------------------------------
// jedro_1_csr_ext_if
// Bundles every non-clock/reset signal between the core (master) and the CSR
// file (slave): CSR access, trap/exception reporting, retire/event strobes,
// interrupt lines and the fetch redirect.
// Modports: master (core side drives requests), slave (CSR file).
// ---------------------------------------------------------------------------
interface jedro_1_csr_ext_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_HPM      = 4,
  parameter int NUM_FAST_IRQ = 4
);
  // Zero-count configurations still need a legal 1-bit vector.
  localparam int HPM_W  = (NUM_HPM > 0) ? NUM_HPM : 1;
  localparam int FAST_W = (NUM_FAST_IRQ > 0) ? NUM_FAST_IRQ : 1;

  logic [11:0]           addr_i;
  logic [DATA_WIDTH-1:0] wdata_i;
  logic [4:0]            uimm_i;
  logic                  uimm_sel_i;
  logic                  we_i;
  logic [1:0]            wmode_i;
  logic [DATA_WIDTH-1:0] rdata_o;
  logic                  csr_illegal_o;
  logic                  exc_valid_i;
  logic [4:0]            exc_cause_i;
  logic [DATA_WIDTH-1:0] exc_pc_i;
  logic [DATA_WIDTH-1:0] exc_tval_i;
  logic                  mret_i;
  logic                  irq_window_i;
  logic [DATA_WIDTH-1:0] curr_pc_i;
  logic                  instr_ret_i;
  logic [HPM_W-1:0]      hpm_event_i;
  logic                  irq_sw_i;
  logic                  irq_timer_i;
  logic                  irq_ext_i;
  logic [FAST_W-1:0]     irq_fast_i;
  logic                  trap_o;
  logic [DATA_WIDTH-1:0] trap_addr_o;

  modport master (
    output addr_i, wdata_i, uimm_i, uimm_sel_i, we_i, wmode_i,
    output exc_valid_i, exc_cause_i, exc_pc_i, exc_tval_i, mret_i,
    output irq_window_i, curr_pc_i, instr_ret_i, hpm_event_i,
    output irq_sw_i, irq_timer_i, irq_ext_i, irq_fast_i,
    input  rdata_o, csr_illegal_o, trap_o, trap_addr_o
  );

  modport slave (
    input  addr_i, wdata_i, uimm_i, uimm_sel_i, we_i, wmode_i,
    input  exc_valid_i, exc_cause_i, exc_pc_i, exc_tval_i, mret_i,
    input  irq_window_i, curr_pc_i, instr_ret_i, hpm_event_i,
    input  irq_sw_i, irq_timer_i, irq_ext_i, irq_fast_i,
    output rdata_o, csr_illegal_o, trap_o, trap_addr_o
  );
endinterface

// File: rtl/jedro_1_csr_counter.sv
// ---------------------------------------------------------------------------
// jedro_1_csr_counter
// One WIDTH-bit event counter exposed as a 64-bit lo/hi CSR pair. Bits above
// WIDTH read 0 and the counter wraps at 2^WIDTH.
// Ports: clk_i, rst_i (sync, active high); inc_i event strobe; inhibit_i
// blocks counting; we_lo_i/we_hi_i replace the low/high 32-bit half with
// wdata_i; count_o zero-extended 64-bit value.
// ---------------------------------------------------------------------------
module jedro_1_csr_counter #(
  parameter int WIDTH = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inc_i,
  input  logic        inhibit_i,
  input  logic        we_lo_i,
  input  logic        we_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] count_o
);
  logic [WIDTH-1:0] count_reg;
  logic [63:0]      count_full;
  logic [63:0]      count_next;
  logic             unused_bits;

  assign count_full = 64'(count_reg);
  assign count_o    = count_full;

  // A CSR write to either half takes precedence over, and swallows, this
  // cycle's increment.
  always_comb begin
    count_next = count_full;
    if (we_lo_i) count_next[31:0]  = wdata_i;
    if (we_hi_i) count_next[63:32] = wdata_i;
    if (!we_lo_i && !we_hi_i && inc_i && !inhibit_i) count_next = count_full + 64'd1;
  end

  // Bits above WIDTH are dropped, which is what makes the counter wrap.
  assign unused_bits = &{1'b0, count_next};

  always_ff @(posedge clk_i) begin
    if (rst_i) count_reg <= '0;
    else       count_reg <= count_next[WIDTH-1:0];
  end
endmodule

// File: rtl/jedro_1_csr_ext.sv
// ---------------------------------------------------------------------------
// jedro_1_csr_ext
// Machine-mode CSR file with 64-bit mcycle/minstret, NUM_HPM event counters,
// mcountinhibit, NUM_FAST_IRQ platform interrupts, vectored mtvec and trap
// entry/return. Produces a registered 1-cycle fetch redirect (trap_o/
// trap_addr_o) for exceptions, mret and taken interrupts.
// Ports: clk_i, rst_i (sync, active high); bus (jedro_1_csr_ext_if.slave)
// carrying CSR access, exception/mret/irq inputs, counter strobes, redirect.
// The interface instance must use the same DATA_WIDTH/NUM_HPM/NUM_FAST_IRQ.
// ---------------------------------------------------------------------------
module jedro_1_csr_ext
  import jedro_1_csr_ext_pkg::*;
#(
  parameter int          DATA_WIDTH         = 32,
  parameter int          NUM_HPM            = 4,
  parameter int          HPM_WIDTH          = 40,
  parameter int          NUM_FAST_IRQ       = 4,
  parameter logic [29:0] TRAP_VEC_BASE_ADDR = TRAP_VEC_BASE_ADDR_DEFAULT
) (
  input logic              clk_i,
  input logic              rst_i,
  jedro_1_csr_ext_if.slave bus
);
  localparam int HPM_W = (NUM_HPM > 0) ? NUM_HPM : 1;

  function automatic logic [31:0] gen_irq_mask();
    logic [31:0] m;
    m = 32'h0000_0888;
    for (int i = 0; i < NUM_FAST_IRQ; i++) m[CSR_MIP_BIT_FAST_BASE + i] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] gen_inhibit_mask();
    logic [31:0] m;
    m = 32'h0000_0005;
    for (int i = 0; i < NUM_HPM; i++) m[3 + i] = 1'b1;
    return m;
  endfunction

  localparam logic [31:0] IRQ_MASK     = gen_irq_mask();
  localparam logic [31:0] INHIBIT_MASK = gen_inhibit_mask();

  logic                  mstatus_mie_reg, mstatus_mpie_reg;
  logic [31:0]           mie_reg, mip_reg, mcountinhibit_reg;
  logic [29:0]           mtvec_base_reg;
  logic                  mtvec_mode_reg;
  logic [DATA_WIDTH-1:0] mscratch_reg, mepc_reg, mtval_reg;
  logic                  mcause_irq_reg;
  logic [4:0]            mcause_code_reg;
  logic [DATA_WIDTH-1:0] rdata_reg, trap_addr_reg;
  logic                  trap_reg;

  logic [31:0]           mip_in, irq_pend;
  logic [4:0]            irq_code;
  logic                  irq_take;
  logic [DATA_WIDTH-1:0] rval, wsrc, wval;
  logic                  csr_known, csr_ro, csr_illegal, csr_we;
  logic [63:0]           mcycle_count, minstret_count;
  logic [63:0]           hpm_count [HPM_W];

  // ---------------- counters ----------------
  jedro_1_csr_counter #(.WIDTH(64)) u_mcycle (
    .clk_i(clk_i), .rst_i(rst_i), .inc_i(1'b1), .inhibit_i(mcountinhibit_reg[0]),
    .we_lo_i(csr_we && bus.addr_i == CSR_ADDR_MCYCLE),
    .we_hi_i(csr_we && bus.addr_i == CSR_ADDR_MCYCLEH),
    .wdata_i(wval), .count_o(mcycle_count)
  );

  jedro_1_csr_counter #(.WIDTH(64)) u_minstret (
    .clk_i(clk_i), .rst_i(rst_i), .inc_i(bus.instr_ret_i), .inhibit_i(mcountinhibit_reg[2]),
    .we_lo_i(csr_we && bus.addr_i == CSR_ADDR_MINSTRET),
    .we_hi_i(csr_we && bus.addr_i == CSR_ADDR_MINSTRETH),
    .wdata_i(wval), .count_o(minstret_count)
  );

  generate
    for (genvar gi = 0; gi < NUM_HPM; gi++) begin : g_hpm
      jedro_1_csr_counter #(.WIDTH(HPM_WIDTH)) u_hpm (
        .clk_i(clk_i), .rst_i(rst_i), .inc_i(bus.hpm_event_i[gi]),
        .inhibit_i(mcountinhibit_reg[3 + gi]),
        .we_lo_i(csr_we && bus.addr_i == 12'(CSR_ADDR_MHPMCOUNTER3 + gi)),
        .we_hi_i(csr_we && bus.addr_i == 12'(CSR_ADDR_MHPMCOUNTER3H + gi)),
        .wdata_i(wval), .count_o(hpm_count[gi])
      );
    end
    if (NUM_HPM == 0) begin : g_no_hpm
      assign hpm_count[0] = 64'd0;
    end
  endgenerate

  // ---------------- interrupts ----------------
  always_comb begin
    mip_in = '0;
    mip_in[CSR_MIP_BIT_MSIP] = bus.irq_sw_i;
    mip_in[CSR_MIP_BIT_MTIP] = bus.irq_timer_i;
    mip_in[CSR_MIP_BIT_MEIP] = bus.irq_ext_i;
    for (int i = 0; i < NUM_FAST_IRQ; i++) mip_in[CSR_MIP_BIT_FAST_BASE + i] = bus.irq_fast_i[i];
  end

  assign irq_pend = mip_reg & mie_reg;

  // Later assignments win: fast lines scanned high-to-low so fast[0] beats
  // the rest, then timer, sw and finally ext override in rising priority.
  always_comb begin
    irq_code = 5'd0;
    for (int i = NUM_FAST_IRQ - 1; i >= 0; i--)
      if (irq_pend[CSR_MIP_BIT_FAST_BASE + i]) irq_code = 5'(CSR_MIP_BIT_FAST_BASE + i);
    if (irq_pend[CSR_MIP_BIT_MTIP]) irq_code = CSR_MCAUSE_IRQ_TIMER;
    if (irq_pend[CSR_MIP_BIT_MSIP]) irq_code = CSR_MCAUSE_IRQ_SW;
    if (irq_pend[CSR_MIP_BIT_MEIP]) irq_code = CSR_MCAUSE_IRQ_EXT;
  end

  assign irq_take = mstatus_mie_reg && (|irq_pend) && bus.irq_window_i
                    && !bus.exc_valid_i && !bus.mret_i;

  // ---------------- CSR read / decode ----------------
  always_comb begin
    rval      = '0;
    csr_known = 1'b1;
    csr_ro    = 1'b0;
    case (bus.addr_i)
      CSR_ADDR_MVENDORID, CSR_ADDR_MARCHID,
      CSR_ADDR_MIMPID, CSR_ADDR_MHARTID: csr_ro = 1'b1;
      CSR_ADDR_MISA: begin
        rval   = MISA_VALUE;
        csr_ro = 1'b1;
      end
      CSR_ADDR_MSTATUS: begin
        rval[3]     = mstatus_mie_reg;
        rval[7]     = mstatus_mpie_reg;
        rval[12:11] = 2'b11;  // MPP fixed to machine mode
      end
      CSR_ADDR_MIE:           rval = mie_reg;
      CSR_ADDR_MTVEC:         rval = {mtvec_base_reg, 1'b0, mtvec_mode_reg};
      CSR_ADDR_MCOUNTINHIBIT: rval = mcountinhibit_reg;
      CSR_ADDR_MSCRATCH:      rval = mscratch_reg;
      CSR_ADDR_MEPC:          rval = mepc_reg;
      CSR_ADDR_MCAUSE:        rval = {mcause_irq_reg, 26'b0, mcause_code_reg};
      CSR_ADDR_MTVAL:         rval = mtval_reg;
      CSR_ADDR_MIP: begin
        rval   = mip_reg;
        csr_ro = 1'b1;
      end
      CSR_ADDR_MCYCLE:        rval = mcycle_count[31:0];
      CSR_ADDR_MCYCLEH:       rval = mcycle_count[63:32];
      CSR_ADDR_MINSTRET:      rval = minstret_count[31:0];
      CSR_ADDR_MINSTRETH:     rval = minstret_count[63:32];
      default: begin
        // The whole HPM counter/event space is legal; unimplemented slots
        // read 0 and have no write target.
        csr_known = (bus.addr_i >= CSR_ADDR_MHPMEVENT3    && bus.addr_i <= CSR_ADDR_MHPMEVENT31)
                 || (bus.addr_i >= CSR_ADDR_MHPMCOUNTER3  && bus.addr_i <= CSR_ADDR_MHPMCOUNTER31)
                 || (bus.addr_i >= CSR_ADDR_MHPMCOUNTER3H && bus.addr_i <= CSR_ADDR_MHPMCOUNTER31H);
        for (int i = 0; i < NUM_HPM; i++) begin
          if (bus.addr_i == 12'(CSR_ADDR_MHPMCOUNTER3 + i))  rval = hpm_count[i][31:0];
          if (bus.addr_i == 12'(CSR_ADDR_MHPMCOUNTER3H + i)) rval = hpm_count[i][63:32];
        end
      end
    endcase
  end

  assign csr_illegal = (bus.we_i || bus.uimm_sel_i) && (csr_ro || !csr_known);
  assign wsrc        = bus.uimm_sel_i ? DATA_WIDTH'(bus.uimm_i) : bus.wdata_i;
  assign wval        = apply_wmode(bus.wmode_i, rval, wsrc);
  assign csr_we      = bus.we_i && !csr_illegal && !bus.exc_valid_i && !bus.mret_i && !irq_take;

  // ---------------- state ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mstatus_mie_reg   <= 1'b0;
      mstatus_mpie_reg  <= 1'b0;
      mie_reg           <= '0;
      mip_reg           <= '0;
      mcountinhibit_reg <= '0;
      mtvec_base_reg    <= TRAP_VEC_BASE_ADDR;
      mtvec_mode_reg    <= CSR_MTVEC_MODE_DIRECT;
      mscratch_reg      <= '0;
      mepc_reg          <= '0;
      mtval_reg         <= '0;
      mcause_irq_reg    <= 1'b0;
      mcause_code_reg   <= '0;
      rdata_reg         <= '0;
      trap_reg          <= 1'b0;
      trap_addr_reg     <= '0;
    end else begin
      rdata_reg <= rval;
      mip_reg   <= mip_in;
      trap_reg  <= bus.exc_valid_i || bus.mret_i || irq_take;
      if (bus.exc_valid_i) begin
        mepc_reg         <= bus.exc_pc_i;
        mcause_irq_reg   <= 1'b0;
        mcause_code_reg  <= bus.exc_cause_i;
        mtval_reg        <= bus.exc_tval_i;
        mstatus_mpie_reg <= mstatus_mie_reg;
        mstatus_mie_reg  <= 1'b0;
        trap_addr_reg    <= {mtvec_base_reg, 2'b00};
      end else if (bus.mret_i) begin
        mstatus_mie_reg  <= mstatus_mpie_reg;
        mstatus_mpie_reg <= 1'b1;
        trap_addr_reg    <= mepc_reg;
      end else if (irq_take) begin
        mepc_reg         <= bus.curr_pc_i;
        mcause_irq_reg   <= 1'b1;
        mcause_code_reg  <= irq_code;
        mtval_reg        <= '0;
        mstatus_mpie_reg <= mstatus_mie_reg;
        mstatus_mie_reg  <= 1'b0;
        if (mtvec_mode_reg == CSR_MTVEC_MODE_VECTORED)
          trap_addr_reg <= {mtvec_base_reg, 2'b00} + {25'b0, irq_code, 2'b00};
        else
          trap_addr_reg <= {mtvec_base_reg, 2'b00};
      end else if (csr_we) begin
        case (bus.addr_i)
          CSR_ADDR_MSTATUS: begin
            mstatus_mie_reg  <= wval[3];
            mstatus_mpie_reg <= wval[7];
          end
          CSR_ADDR_MIE:           mie_reg <= wval & IRQ_MASK;
          CSR_ADDR_MTVEC: begin
            mtvec_base_reg <= wval[31:2];
            mtvec_mode_reg <= wval[0];
          end
          CSR_ADDR_MCOUNTINHIBIT: mcountinhibit_reg <= wval & INHIBIT_MASK;
          CSR_ADDR_MSCRATCH:      mscratch_reg <= wval;
          CSR_ADDR_MEPC:          mepc_reg <= wval;
          CSR_ADDR_MCAUSE: begin
            mcause_irq_reg  <= wval[31];
            mcause_code_reg <= wval[4:0];
          end
          CSR_ADDR_MTVAL:         mtval_reg <= wval;
          default: ;
        endcase
      end
    end
  end

  assign bus.rdata_o       = rdata_reg;
  assign bus.csr_illegal_o = csr_illegal;
  assign bus.trap_o        = trap_reg;
  assign bus.trap_addr_o   = trap_addr_reg;
endmodule
